// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared constants and types for the ring-oscillator TRNG sampler
package trng_pkg;

    localparam int N_RO_DEF      = 32;
    localparam int WORD_W_DEF    = 32;
    localparam int DIV_DEF       = 4;
    localparam int REP_LIMIT_DEF = 64;

    typedef enum logic {
        VN_EMPTY      = 1'b0,
        VN_HAVE_FIRST = 1'b1
    } vn_state_t;

    // Counter width helper that never returns zero, so DIV=1 still gets a 1-bit counter
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/vn_corrector.sv
// rtl/vn_corrector.sv - von Neumann pair debiaser with bypass
module vn_corrector
    import trng_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_sample,
    input  logic i_tick,
    input  logic i_bypass,
    output logic o_bit,
    output logic o_bit_valid
);

    vn_state_t r_state;
    vn_state_t w_state_next;
    logic      r_first;

    // State register; also remembers the first sample of a pair
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_state <= VN_EMPTY;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (i_tick && !i_bypass && (r_state == VN_EMPTY)) begin
                r_first <= i_sample;
            end
        end
    end

    // Next state: each sample toggles between waiting for first and second of a pair
    always_comb begin
        w_state_next = r_state;
        if (i_bypass) begin
            w_state_next = VN_EMPTY;
        end else if (i_tick) begin
            w_state_next = (r_state == VN_EMPTY) ? VN_HAVE_FIRST : VN_EMPTY;
        end
    end

    // Output: bypass forwards every sample; otherwise an unequal pair yields its first bit
    always_comb begin
        o_bit       = i_bypass ? i_sample : r_first;
        o_bit_valid = 1'b0;
        if (i_tick) begin
            o_bit_valid = i_bypass ||
                          ((r_state == VN_HAVE_FIRST) && (i_sample != r_first));
        end
    end

endmodule

// File: rtl/ro_sampler.sv
// rtl/ro_sampler.sv - ring-oscillator sampler with debiasing, word packing and repetition health test
module ro_sampler
    import trng_pkg::*;
#(
    parameter int N_RO      = N_RO_DEF,
    parameter int DIV       = DIV_DEF,
    parameter int WORD_W    = WORD_W_DEF,
    parameter int REP_LIMIT = REP_LIMIT_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic              VN_EN,
    input  logic [N_RO-1:0]   RO_IN,
    output logic [WORD_W-1:0] DATA_O,
    output logic              VALID_O,
    input  logic              READY_I,
    output logic              HEALTH_FAIL_O
);

    localparam int DIV_W = clog2_min1(DIV);
    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int REP_W = $clog2(REP_LIMIT + 1);

    logic [N_RO-1:0]   r_sync1;
    logic [N_RO-1:0]   r_sync2;
    logic [DIV_W-1:0]  r_div;
    logic              r_sample;
    logic              r_samp_vld;
    logic              r_vn_en;
    logic [REP_W-1:0]  r_rep_cnt;
    logic              r_fail;
    logic [WORD_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;

    logic              w_raw;
    logic              w_tick;
    logic [REP_W-1:0]  w_rep_next;
    logic              w_bit;
    logic              w_bit_vld;
    logic              w_full;
    logic              w_take;
    logic              w_load;

    assign w_raw  = ^r_sync2;
    assign w_tick = EN && (r_div == DIV_W'(DIV - 1));
    assign w_full = (r_cnt == CNT_W'(WORD_W));
    assign w_take = r_valid && READY_I;
    assign w_load = EN && !r_fail && w_full && (!r_valid || w_take);

    assign DATA_O        = r_data;
    assign VALID_O       = r_valid;
    assign HEALTH_FAIL_O = r_fail;

    // Two-flop synchronizer on every oscillator line
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= RO_IN;
            r_sync2 <= r_sync1;
        end
    end

    // Sample-tick divider, parked at zero while sampling is disabled
    always_ff @(posedge CLK) begin
        if (RESET || !EN || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Correction mode is latched only while idle so a word never mixes modes
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_vn_en <= 1'b0;
        end else if (!EN) begin
            r_vn_en <= VN_EN;
        end
    end

    // Run length of the incoming raw sample; zero means no previous sample yet
    always_comb begin
        w_rep_next = r_rep_cnt;
        if ((r_rep_cnt == '0) || (w_raw != r_sample)) begin
            w_rep_next = REP_W'(1);
        end else if (r_rep_cnt != REP_W'(REP_LIMIT)) begin
            w_rep_next = r_rep_cnt + REP_W'(1);
        end
    end

    // Sample register, its one-cycle valid strobe and the repetition counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sample   <= 1'b0;
            r_samp_vld <= 1'b0;
            r_rep_cnt  <= '0;
        end else begin
            r_samp_vld <= w_tick;
            if (!EN) begin
                r_rep_cnt <= '0;
            end else if (w_tick) begin
                r_sample  <= w_raw;
                r_rep_cnt <= w_rep_next;
            end
        end
    end

    // Sticky health failure; only reset clears it
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fail <= 1'b0;
        end else if (w_tick && (w_rep_next == REP_W'(REP_LIMIT))) begin
            r_fail <= 1'b1;
        end
    end

    vn_corrector u_vn (
        .i_clk       (CLK),
        .i_reset     (RESET),
        .i_clear     (!EN),
        .i_sample    (r_sample),
        .i_tick      (r_samp_vld),
        .i_bypass    (!r_vn_en),
        .o_bit       (w_bit),
        .o_bit_valid (w_bit_vld)
    );

    // Accumulator: new bits enter at the LSB; a full word waits for the holding register
    always_ff @(posedge CLK) begin
        if (RESET || !EN || r_fail) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_acc <= {r_acc[WORD_W-2:0], w_bit};
            r_cnt <= w_bit_vld ? CNT_W'(1) : CNT_W'(0);
        end else if (w_bit_vld && !w_full) begin
            r_acc <= {r_acc[WORD_W-2:0], w_bit};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Holding register: loads on a free slot or on the cycle its word is taken
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= r_acc;
            r_valid <= 1'b1;
        end else if (w_take) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ro_sampler.sv
// tb/tb_ro_sampler.sv - randomized directed bench for ro_sampler with a bit-stream reference model
module tb_ro_sampler;

    logic        CLK;
    logic        RESET;
    logic        EN;
    logic        VN_EN;
    logic [31:0] RO_IN;
    logic [31:0] DATA_O;
    logic        VALID_O;
    logic        READY_I;
    logic        HEALTH_FAIL_O;

    int          n_assert = 0;
    int          n_fail   = 0;

    logic [31:0] recv[$];
    bit          samp[$];
    bit          bits_q[$];
    bit          model_vn;

    bit          watch;
    int          stall_low;
    int          stall_chg;
    logic        prev_valid;
    logic        prev_take;
    logic [31:0] prev_data;
    logic [31:0] first_word;

    ro_sampler #(
        .N_RO      (32),
        .DIV       (4),
        .WORD_W    (32),
        .REP_LIMIT (64)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .EN            (EN),
        .VN_EN         (VN_EN),
        .RO_IN         (RO_IN),
        .DATA_O        (DATA_O),
        .VALID_O       (VALID_O),
        .READY_I       (READY_I),
        .HEALTH_FAIL_O (HEALTH_FAIL_O)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!RESET && VALID_O && READY_I) recv.push_back(DATA_O);
        if (watch) begin
            if (!VALID_O) stall_low++;
            if (prev_valid && !prev_take && (DATA_O !== prev_data)) stall_chg++;
        end
        prev_valid = VALID_O;
        prev_take  = VALID_O && READY_I;
        prev_data  = DATA_O;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_recv(input int j);
        if (j < recv.size()) return recv[j];
        return 32'hxxxxxxxx;
    endfunction

    function automatic void build_bits();
        bits_q.delete();
        if (!model_vn) begin
            foreach (samp[i]) bits_q.push_back(samp[i]);
        end else begin
            for (int i = 0; i + 1 < samp.size(); i += 2)
                if (samp[i] != samp[i+1]) bits_q.push_back(samp[i]);
        end
    endfunction

    function automatic logic [31:0] exp_word(input int j);
        logic [31:0] w = '0;
        for (int b = 0; b < 32; b++) w = {w[30:0], logic'(bits_q[32*j + b])};
        return w;
    endfunction

    // Holds one raw value for a whole tick period; entered and left at posedge+1
    task automatic drive_sample(input bit raw);
        logic [31:0] v;
        v = $urandom;
        if ((^v) != raw) v[0] = ~v[0];
        RO_IN = v;
        samp.push_back(raw);
        repeat (4) @(posedge CLK);
        #1;
    endtask

    task automatic start_stream(input bit vn);
        samp.delete();
        recv.delete();
        model_vn = vn;
        VN_EN    = vn;
        @(posedge CLK);
        #1;
        EN = 1'b1;
    endtask

    task automatic end_stream();
        repeat (2) @(posedge CLK);
        #1;
        EN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        CLK = 1'b0; RESET = 1'b1; EN = 1'b0; VN_EN = 1'b0; RO_IN = '0; READY_I = 1'b0;
        watch = 1'b0; stall_low = 0; stall_chg = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_data", DATA_O, 32'h0);
        check("reset_valid", VALID_O, 1'b0);
        check("reset_health", HEALTH_FAIL_O, 1'b0);
        RESET = 1'b0;

        // Bypass mode: alternating raw bits then random
        READY_I = 1'b1;
        start_stream(1'b0);
        for (int i = 0; i < 32; i++) begin
            drive_sample((i % 2) == 0);
            if (i == 30) check("a_no_valid_before_32", VALID_O, 1'b0);
        end
        for (int i = 0; i < 64; i++) drive_sample(1'($urandom_range(0, 1)));
        end_stream();
        build_bits();
        check("a_word_count", recv.size(), bits_q.size() / 32);
        check("a_word0_alt", get_recv(0), 32'hAAAAAAAA);
        for (int j = 0; j < bits_q.size() / 32; j++) check("a_word", get_recv(j), exp_word(j));

        // Von Neumann mode: patterned pairs then random
        start_stream(1'b1);
        for (int i = 0; i < 16; i++) begin
            drive_sample(1); drive_sample(0);
            drive_sample(1); drive_sample(1);
            drive_sample(0); drive_sample(1);
        end
        for (int i = 0; i < 256; i++) drive_sample(1'($urandom_range(0, 1)));
        end_stream();
        build_bits();
        check("b_word_count", recv.size(), bits_q.size() / 32);
        check("b_word0_alt", get_recv(0), 32'hAAAAAAAA);
        for (int j = 0; j < bits_q.size() / 32; j++) check("b_word", get_recv(j), exp_word(j));

        // Backpressure: consumer stalls for 100 ticks after the first word
        READY_I = 1'b0;
        start_stream(1'b0);
        for (int i = 0; i < 33; i++) drive_sample(1'($urandom_range(0, 1)));
        check("c_first_loaded", VALID_O, 1'b1);
        stall_low = 0; stall_chg = 0; watch = 1'b1;
        for (int i = 0; i < 99; i++) drive_sample(1'($urandom_range(0, 1)));
        READY_I = 1'b1;
        @(posedge CLK);
        #1;
        watch = 1'b0;
        end_stream();
        build_bits();
        check("c_valid_never_low", stall_low, 0);
        check("c_data_stable", stall_chg, 0);
        check("c_word_count", recv.size(), 2);
        check("c_word0", get_recv(0), exp_word(0));
        check("c_word1_no_overwrite", get_recv(1), exp_word(1));

        // Reset after 17 accumulated bits, sampling left enabled
        READY_I = 1'b1;
        start_stream(1'b0);
        for (int i = 0; i < 17; i++) drive_sample(1'($urandom_range(0, 1)));
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("d_reset_data", DATA_O, 32'h0);
        check("d_reset_valid", VALID_O, 1'b0);
        check("d_reset_health", HEALTH_FAIL_O, 1'b0);
        RESET = 1'b0;
        samp.delete();
        recv.delete();
        for (int i = 0; i < 31; i++) drive_sample(1'($urandom_range(0, 1)));
        end_stream();
        check("d_no_word_from_31", recv.size(), 0);
        start_stream(1'b0);
        for (int i = 0; i < 32; i++) drive_sample(1'($urandom_range(0, 1)));
        end_stream();
        build_bits();
        check("d_fresh_count", recv.size(), 1);
        check("d_fresh_word", get_recv(0), exp_word(0));

        // One-cycle EN drop mid-word with a pending word held
        READY_I = 1'b0;
        start_stream(1'b0);
        for (int i = 0; i < 42; i++) drive_sample(1'($urandom_range(0, 1)));
        EN = 1'b0;
        @(posedge CLK);
        #1;
        build_bits();
        first_word = exp_word(0);
        samp.delete();
        EN = 1'b1;
        for (int i = 0; i < 32; i++) drive_sample(1'($urandom_range(0, 1)));
        READY_I = 1'b1;
        end_stream();
        build_bits();
        check("e_word_count", recv.size(), 2);
        check("e_pending_intact", get_recv(0), first_word);
        check("e_partial_dropped", get_recv(1), exp_word(0));

        // Repetition health test with a constant raw value
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        READY_I = 1'b0;
        start_stream(1'b0);
        for (int i = 0; i < 63; i++) drive_sample(1);
        check("f_no_fail_at_63", HEALTH_FAIL_O, 1'b0);
        drive_sample(1);
        check("f_fail_at_64", HEALTH_FAIL_O, 1'b1);
        for (int i = 0; i < 40; i++) drive_sample(1);
        READY_I = 1'b1;
        end_stream();
        check("f_word_count", recv.size(), 1);
        check("f_held_word", get_recv(0), 32'hFFFFFFFF);
        check("f_fail_sticky", HEALTH_FAIL_O, 1'b1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("f_fail_cleared", HEALTH_FAIL_O, 1'b0);
        RESET = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
